abl: RTL and testbench

// - Next-value logic and registers for ABL (Address Bus Low) and PCL (Program Counter low).
// - Sits directly upstream of the ABH stage. Its unregistered carry-out CO drives ABH's CI
//   in the same cycle, so ABH and ABL together form one 16-bit address add.
// - Also registers a page-cross flag that the microcode sequencer uses for indexed-mode fixup cycles.
//

---
 rtl/abl_pkg.sv | 30 +++
 rtl/abl_if.sv | 23 ++
 rtl/abl_add8_co.sv | 16 +
 rtl/abl.sv | 80 ++++++++
 tb/tb_abl.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/abl_pkg.sv
// Shared definitions for the ABL/PCL address stage: op field encodings and an op builder.
// The microcode ROM generator imports this package too, so encodings live only here.
package abl_pkg;

  localparam logic [1:0] BASE_ZERO = 2'b00;
  localparam logic [1:0] BASE_ABL  = 2'b01;
  localparam logic [1:0] BASE_PCL  = 2'b10;
  localparam logic [1:0] BASE_DB   = 2'b11;

  localparam logic [1:0] ADD_ZERO  = 2'b00;
  localparam logic [1:0] ADD_REG   = 2'b01;
  localparam logic [1:0] ADD_DB    = 2'b10;
  localparam logic [1:0] ADD_M1    = 2'b11;

  localparam logic [7:0] ABL_RST_DEFAULT = 8'hFC;
  localparam logic [7:0] PCL_RST_DEFAULT = 8'h00;

  typedef struct packed {
    logic [1:0] base_sel;
    logic [1:0] add_sel;
    logic       ci;
  } abl_op_t;

  function automatic logic [4:0] make_op(input logic [1:0] base,
                                         input logic [1:0] addend,
                                         input logic       ci);
    return {base, addend, ci};
  endfunction

endpackage

// File: rtl/abl_if.sv
// Bus between the microcode sequencer (master) and the ABL/PCL stage (slave).
interface abl_if;
  logic [7:0] DB;
  logic [7:0] REG;
  logic [4:0] op;
  logic       ld_pc;
  logic       inc_pc;
  logic [7:0] ADL;
  logic       CO;
  logic [7:0] ABL;
  logic [7:0] PCL;
  logic       page_cross;

  modport master (
    output DB, REG, op, ld_pc, inc_pc,
    input  ADL, CO, ABL, PCL, page_cross
  );

  modport slave (
    input  DB, REG, op, ld_pc, inc_pc,
    output ADL, CO, ABL, PCL, page_cross
  );
endinterface

// File: rtl/abl_add8_co.sv
// 8-bit adder with carry-in and carry-out; shared by the address stages.
module add8_co (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] sum,
  output logic       co
);

  logic [8:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {8'b0, ci};
  assign sum  = full[7:0];
  assign co   = full[8];

endmodule

// File: rtl/abl.sv
// ABL/PCL next-value logic and registers. ADL/CO are combinational so ABH can chain
// its carry in the same cycle; page_cross is CO delayed one cycle for fixup microcode.
module abl
  import abl_pkg::*;
#(
  parameter logic [7:0] RST_ABL = ABL_RST_DEFAULT,
  parameter logic [7:0] RST_PCL = PCL_RST_DEFAULT
) (
  input  logic   clk,
  input  logic   RST,
  abl_if.slave   bus
);

  abl_op_t    op_s;
  logic [7:0] base;
  logic [7:0] addend;
  logic [7:0] adl;
  logic       co;

  logic [7:0] abl_d, abl_q;
  logic [7:0] pcl_d, pcl_q;
  logic       page_cross_d, page_cross_q;

  assign op_s = abl_op_t'(bus.op);

  always_comb begin
    base = 8'h00;
    unique case (op_s.base_sel)
      BASE_ZERO: base = 8'h00;
      BASE_ABL:  base = abl_q;
      BASE_PCL:  base = pcl_q;
      BASE_DB:   base = bus.DB;
    endcase
  end

  always_comb begin
    addend = 8'h00;
    unique case (op_s.add_sel)
      ADD_ZERO: addend = 8'h00;
      ADD_REG:  addend = bus.REG;
      ADD_DB:   addend = bus.DB;
      ADD_M1:   addend = 8'hFF;
    endcase
  end

  add8_co u_add (
    .a   (base),
    .b   (addend),
    .ci  (op_s.ci),
    .sum (adl),
    .co  (co)
  );

  // PCL loads from the registered ABL, so a value reaches PCL one cycle after it is on ABL.
  always_comb begin
    abl_d        = adl;
    page_cross_d = co;
    pcl_d        = pcl_q;
    if (bus.ld_pc) pcl_d = abl_q + {7'b0, bus.inc_pc};
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      abl_q        <= RST_ABL;
      pcl_q        <= RST_PCL;
      page_cross_q <= 1'b0;
    end else begin
      abl_q        <= abl_d;
      pcl_q        <= pcl_d;
      page_cross_q <= page_cross_d;
    end
  end

  assign bus.ADL        = adl;
  assign bus.CO         = co;
  assign bus.ABL        = abl_q;
  assign bus.PCL        = pcl_q;
  assign bus.page_cross = page_cross_q;

endmodule

// File: tb/tb_abl.sv
// Directed bench for abl: hand sequences for reset/PCL corner cases plus a vector table.
module tb_abl;
  import abl_pkg::*;

  logic clk;
  logic RST;
  int   n_checks;
  int   n_fail;

  abl_if bus ();

  abl u_dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pre_abl;
    logic [7:0] db;
    logic [7:0] rg;
    logic [4:0] op;
    logic [7:0] exp_adl;
    logic       exp_co;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_abl(input logic [7:0] v);
    bus.DB    = v;
    bus.op    = make_op(BASE_DB, ADD_ZERO, 1'b0);
    bus.ld_pc = 1'b0;
    tick();
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    RST        = 1'b0;
    bus.DB     = 8'h00;
    bus.REG    = 8'h00;
    bus.op     = 5'b0;
    bus.ld_pc  = 1'b0;
    bus.inc_pc = 1'b0;

    vecs[0] = '{8'hF0, 8'h00, 8'h20, make_op(BASE_ABL,  ADD_REG,  1'b0), 8'h10, 1'b1};
    vecs[1] = '{8'h00, 8'h12, 8'h05, make_op(BASE_DB,   ADD_REG,  1'b0), 8'h17, 1'b0};
    vecs[2] = '{8'h00, 8'hFF, 8'h00, make_op(BASE_DB,   ADD_ZERO, 1'b1), 8'h00, 1'b1};
    vecs[3] = '{8'h00, 8'hFF, 8'h00, make_op(BASE_DB,   ADD_M1,   1'b1), 8'hFF, 1'b1};
    vecs[4] = '{8'h00, 8'h81, 8'h00, make_op(BASE_DB,   ADD_DB,   1'b1), 8'h03, 1'b1};
    vecs[5] = '{8'h55, 8'h00, 8'h00, make_op(BASE_ABL,  ADD_M1,   1'b0), 8'h54, 1'b1};
    vecs[6] = '{8'h33, 8'hAA, 8'hBB, make_op(BASE_ZERO, ADD_ZERO, 1'b0), 8'h00, 1'b0};
    vecs[7] = '{8'h7F, 8'h00, 8'h00, make_op(BASE_ABL,  ADD_ZERO, 1'b1), 8'h80, 1'b0};
    vecs[8] = '{8'h00, 8'h00, 8'h3C, make_op(BASE_ZERO, ADD_REG,  1'b1), 8'h3D, 1'b0};

    // Power-on reset, with ADL still tracking inputs while RST is held.
    #2 RST = 1'b1;
    #1;
    check("por_abl", {1'b0, bus.ABL}, 9'h0FC);
    check("por_pcl", {1'b0, bus.PCL}, 9'h000);
    check("por_page_cross", {8'b0, bus.page_cross}, 9'h000);
    bus.DB  = 8'h12;
    bus.REG = 8'h05;
    bus.op  = make_op(BASE_DB, ADD_REG, 1'b0);
    #1;
    check("rst_adl_comb", {bus.CO, bus.ADL}, 9'h017);
    bus.op = make_op(BASE_ABL, ADD_ZERO, 1'b1);
    #1;
    check("rst_adl_from_abl", {bus.CO, bus.ADL}, 9'h0FD);
    bus.op = make_op(BASE_DB, ADD_REG, 1'b0);
    tick();
    check("rst_hold_abl", {1'b0, bus.ABL}, 9'h0FC);
    #1 RST = 1'b0;
    tick();
    check("first_edge_abl", {1'b0, bus.ABL}, 9'h017);
    check("first_edge_page_cross", {8'b0, bus.page_cross}, 9'h000);

    // Load PCL and set page_cross so the mid-cycle reset has something to clear.
    set_abl(8'h5A);
    bus.DB    = 8'h9B;
    bus.op    = make_op(BASE_DB, ADD_DB, 1'b1);
    bus.ld_pc = 1'b1;
    tick();
    bus.ld_pc = 1'b0;
    check("pre_rst_pcl", {1'b0, bus.PCL}, 9'h05A);
    check("pre_rst_abl", {1'b0, bus.ABL}, 9'h037);
    check("pre_rst_page_cross", {8'b0, bus.page_cross}, 9'h001);
    #2 RST = 1'b1;
    #1;
    check("mid_rst_abl", {1'b0, bus.ABL}, 9'h0FC);
    check("mid_rst_pcl", {1'b0, bus.PCL}, 9'h000);
    check("mid_rst_page_cross", {8'b0, bus.page_cross}, 9'h000);
    #1 RST = 1'b0;

    // Decrement of PCL via 0xFF addend.
    bus.op = make_op(BASE_PCL, ADD_M1, 1'b0);
    #1;
    check("dec_borrow", {bus.CO, bus.ADL}, 9'h0FF);
    bus.op = make_op(BASE_PCL, ADD_M1, 1'b1);
    #1;
    check("dec_ci", {bus.CO, bus.ADL}, 9'h100);
    tick();

    // PCL increment with wrap, then hold with inc_pc ignored.
    set_abl(8'h5A);
    bus.DB    = 8'hFF;
    bus.ld_pc = 1'b1;
    bus.inc_pc = 1'b0;
    tick();
    check("pcl_load_5a", {1'b0, bus.PCL}, 9'h05A);
    check("abl_ff", {1'b0, bus.ABL}, 9'h0FF);
    bus.inc_pc = 1'b1;
    bus.DB     = 8'h11;
    tick();
    check("pcl_inc_wrap", {1'b0, bus.PCL}, 9'h000);
    bus.ld_pc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.DB = 8'(i * 8'h21 + 8'h03);
      tick();
      check($sformatf("pcl_hold_%0d", i), {1'b0, bus.PCL}, 9'h000);
    end
    bus.inc_pc = 1'b0;

    // Simultaneous ABL update and PCL load from old ABL.
    set_abl(8'h40);
    bus.DB    = 8'h99;
    bus.op    = make_op(BASE_ZERO, ADD_DB, 1'b0);
    bus.ld_pc = 1'b1;
    tick();
    bus.ld_pc = 1'b0;
    check("simul_abl", {1'b0, bus.ABL}, 9'h099);
    check("simul_pcl", {1'b0, bus.PCL}, 9'h040);

    // Vector table: combinational ADL/CO, then registered ABL/page_cross.
    for (int i = 0; i < 9; i++) begin
      set_abl(vecs[i].pre_abl);
      bus.DB  = vecs[i].db;
      bus.REG = vecs[i].rg;
      bus.op  = vecs[i].op;
      #1;
      check($sformatf("vec%0d_adl", i), {1'b0, bus.ADL}, {1'b0, vecs[i].exp_adl});
      check($sformatf("vec%0d_co", i), {8'b0, bus.CO}, {8'b0, vecs[i].exp_co});
      tick();
      check($sformatf("vec%0d_abl", i), {1'b0, bus.ABL}, {1'b0, vecs[i].exp_adl});
      check($sformatf("vec%0d_page_cross", i), {8'b0, bus.page_cross}, {8'b0, vecs[i].exp_co});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
